cpu_debug_engine: RTL

CPU_DEBUG_ENGINE -- requirements
Module: cpu_debug_engine

---
 rtl/cpu_debug_engine.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_debug_engine.sv
// Debug engine: byte-command front end that peeks/pokes control registers,
// single-steps or free-runs the CPU under a clock enable, and streams memory
// and register-file contents back over a byte reply channel.
module cpu_debug_engine #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int NUM_REGS     = 16,
    parameter int MEM_LAT      = 1,
    parameter int STEP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              cpu_clk_en,
    input  logic [7:0]        cpu_state,
    input  logic              halted,
    input  logic [ADDR_W-1:0] pc,
    output logic [3:0]        reg_addr,
    output logic              reg_addr_en,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              debug_en,
    output logic              rst_req,
    output logic              busy
);
    localparam int BPW = DATA_W / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int LW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int TW  = ($clog2(STEP_TIMEOUT + 1) < 2) ? 2 : $clog2(STEP_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REPLY, S_STEP, S_RUN, S_DUMP_WAIT,
        S_DUMP_TX, S_DUMP_CSUM, S_REGS_WAIT, S_REGS_TX
    } state_t;

    state_t            r_state, w_state_next;
    logic [7:0]        r_ctrl [8];
    logic [2:0]        r_sel;
    logic              r_bp_hit;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_csum;
    logic [DATA_W-1:0] r_word;
    logic [BW-1:0]     r_byte;
    logic [15:0]       r_len;
    logic [LW-1:0]     r_wait;
    logic [TW-1:0]     r_cnt;
    logic              r_ran;
    logic [3:0]        r_reg_idx;
    logic              r_armed;

    logic              w_debug, w_rx_fire, w_tx_fire, w_last_byte;
    logic [3:0]        w_op;
    logic [2:0]        w_idx;
    logic [7:0]        w_status;
    logic [15:0]       w_rd16, w_bp16, w_start16;
    logic [ADDR_W-1:0] w_bp, w_start;
    logic [DATA_W-1:0] w_word_shift;
    logic              w_step_done, w_step_tmo, w_step_stop;
    logic              w_run_bp, w_run_brk, w_run_stop;

    assign w_bp16    = {r_ctrl[7], r_ctrl[6]};
    assign w_start16 = {r_ctrl[3], r_ctrl[2]};

    // Fit the 16-bit control-register addresses and register readback to the parameter widths
    generate
        if (ADDR_W <= 16) begin : g_addr_narrow
            assign w_bp    = w_bp16[ADDR_W-1:0];
            assign w_start = w_start16[ADDR_W-1:0];
        end else begin : g_addr_wide
            assign w_bp    = {{(ADDR_W-16){1'b0}}, w_bp16};
            assign w_start = {{(ADDR_W-16){1'b0}}, w_start16};
        end
        if (DATA_W >= 16) begin : g_rd_wide
            assign w_rd16 = reg_rdata[15:0];
        end else begin : g_rd_narrow
            assign w_rd16 = {{(16-DATA_W){1'b0}}, reg_rdata};
        end
    endgenerate

    assign w_debug      = r_ctrl[0][0];
    assign w_op         = rx_data[3:0];
    assign w_idx        = rx_data[6:4];
    assign w_rx_fire    = rx_valid && rx_ready;
    assign w_tx_fire    = r_tx_valid && tx_ready;
    assign w_last_byte  = (r_byte == BW'(BPW - 1));
    assign w_word_shift = r_word >> 8;

    // STEP stops once the CPU is back at an instruction boundary (after >=2 enabled cycles) or halts
    assign w_step_done = halted || ((r_cnt >= TW'(2)) && (cpu_state == 8'd0));
    assign w_step_tmo  = (r_cnt == TW'(STEP_TIMEOUT));
    assign w_step_stop = w_step_done || w_step_tmo;
    // RUN breakpoint is only honoured once the CPU has had at least one enabled cycle
    assign w_run_bp    = r_ran && (cpu_state == 8'd0) && (pc == w_bp);
    assign w_run_brk   = w_rx_fire && (w_op == 4'h7);
    assign w_run_stop  = w_run_bp || halted || w_run_brk;

    assign rx_ready    = r_armed && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign cpu_clk_en  = !w_debug || ((r_state == S_STEP) && !w_step_stop)
                                  || ((r_state == S_RUN) && !w_run_stop);
    assign reg_addr_en = ((r_state == S_REGS_WAIT) || (r_state == S_REGS_TX)) ? 1'b1
                                                                              : (w_debug & r_ctrl[0][1]);
    assign reg_addr    = ((r_state == S_REGS_WAIT) || (r_state == S_REGS_TX)) ? r_reg_idx
                                                                              : r_ctrl[1][3:0];
    assign mem_addr    = r_mem_addr;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign debug_en    = w_debug;
    assign rst_req     = r_ctrl[0][2];
    assign busy        = (r_state != S_IDLE);

    // Readable status bytes selected by GET
    always_comb begin
        w_status = 8'h00;
        case (w_idx)
            3'd0:    w_status = w_rd16[7:0];
            3'd1:    w_status = w_rd16[15:8];
            3'd7:    w_status = {6'b0, r_bp_hit, halted};
            default: w_status = 8'h00;
        endcase
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_rx_fire) begin
                case (w_op)
                    4'h1, 4'h2, 4'h4, 4'h8: w_state_next = S_REPLY;
                    4'hC:    w_state_next = w_debug ? S_STEP : S_REPLY;
                    4'h6:    w_state_next = w_debug ? S_RUN  : S_REPLY;
                    4'hE:    w_state_next = ({r_ctrl[5], r_ctrl[4]} == 16'd0) ? S_DUMP_CSUM : S_DUMP_WAIT;
                    4'hA:    w_state_next = S_REGS_WAIT;
                    default: w_state_next = S_IDLE;
                endcase
            end
            S_REPLY:     if (w_tx_fire) w_state_next = S_IDLE;
            S_STEP:      if (w_step_stop) w_state_next = S_REPLY;
            S_RUN:       if (w_run_stop) w_state_next = S_REPLY;
            S_DUMP_WAIT: if (r_wait == LW'(MEM_LAT - 1)) w_state_next = S_DUMP_TX;
            S_DUMP_TX:   if (w_tx_fire && w_last_byte)
                             w_state_next = (r_len == 16'd1) ? S_DUMP_CSUM : S_DUMP_WAIT;
            S_DUMP_CSUM: if (w_tx_fire) w_state_next = S_IDLE;
            S_REGS_WAIT: w_state_next = S_REGS_TX;
            S_REGS_TX:   if (w_tx_fire && w_last_byte)
                             w_state_next = (r_reg_idx == 4'(NUM_REGS - 1)) ? S_IDLE : S_REGS_WAIT;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Control registers, reply byte, dump/step datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) r_ctrl[i] <= 8'h00;
            r_sel <= 3'd0; r_bp_hit <= 1'b0; r_tx_data <= 8'h00; r_tx_valid <= 1'b0;
            r_mem_addr <= '0; r_csum <= 8'h00; r_word <= '0; r_byte <= '0;
            r_len <= 16'd0; r_wait <= '0; r_cnt <= '0; r_ran <= 1'b0;
            r_reg_idx <= 4'd0; r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE: if (w_rx_fire) begin
                    case (w_op)
                        4'h1: begin r_tx_data <= w_status; r_tx_valid <= 1'b1; end
                        4'h2: begin r_sel <= w_idx; r_tx_data <= 8'hAB; r_tx_valid <= 1'b1; end
                        4'h4: begin r_ctrl[r_sel][7:4] <= rx_data[7:4]; r_tx_data <= 8'hAB; r_tx_valid <= 1'b1; end
                        4'h8: begin r_ctrl[r_sel][3:0] <= rx_data[7:4]; r_tx_data <= 8'hAB; r_tx_valid <= 1'b1; end
                        4'hC, 4'h6: begin
                            r_bp_hit <= 1'b0; r_cnt <= '0; r_ran <= 1'b0;
                            if (!w_debug) begin r_tx_data <= 8'hEE; r_tx_valid <= 1'b1; end
                        end
                        4'hE: begin
                            r_mem_addr <= w_start; r_len <= {r_ctrl[5], r_ctrl[4]};
                            r_csum <= 8'h00; r_wait <= '0;
                            if ({r_ctrl[5], r_ctrl[4]} == 16'd0) begin r_tx_data <= 8'h00; r_tx_valid <= 1'b1; end
                        end
                        4'hA: r_reg_idx <= 4'd0;
                        default: ;
                    endcase
                end
                S_REPLY, S_DUMP_CSUM: if (w_tx_fire) r_tx_valid <= 1'b0;
                S_STEP: begin
                    if (w_step_stop) begin
                        r_tx_data <= w_step_done ? 8'hAB : 8'hEE; r_tx_valid <= 1'b1;
                    end else r_cnt <= r_cnt + TW'(1);
                end
                S_RUN: begin
                    if (w_run_stop) begin
                        r_bp_hit <= w_run_bp; r_tx_data <= w_run_bp ? 8'hB1 : 8'hAB; r_tx_valid <= 1'b1;
                    end else r_ran <= 1'b1;
                end
                S_DUMP_WAIT: begin
                    if (r_wait == LW'(MEM_LAT - 1)) begin
                        r_wait <= '0; r_word <= mem_rdata; r_byte <= '0;
                        r_tx_data <= mem_rdata[7:0]; r_tx_valid <= 1'b1;
                    end else r_wait <= r_wait + LW'(1);
                end
                S_DUMP_TX: if (w_tx_fire) begin
                    r_csum <= r_csum ^ r_tx_data;
                    if (w_last_byte) begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_len <= r_len - 16'd1;
                        // Final word: the checksum byte follows directly, folding in the byte just sent
                        r_tx_data <= r_csum ^ r_tx_data;
                        r_tx_valid <= (r_len == 16'd1);
                    end else begin
                        r_byte <= r_byte + BW'(1); r_word <= w_word_shift; r_tx_data <= w_word_shift[7:0];
                    end
                end
                S_REGS_WAIT: begin
                    r_word <= reg_rdata; r_byte <= '0; r_tx_data <= reg_rdata[7:0]; r_tx_valid <= 1'b1;
                end
                S_REGS_TX: if (w_tx_fire) begin
                    if (w_last_byte) begin
                        r_tx_valid <= 1'b0;
                        if (r_reg_idx != 4'(NUM_REGS - 1)) r_reg_idx <= r_reg_idx + 4'd1;
                    end else begin
                        r_byte <= r_byte + BW'(1); r_word <= w_word_shift; r_tx_data <= w_word_shift[7:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
